// File: rtl/ahb_apb_pkg.sv
// ahb_apb_pkg: shared definitions for the AHB side of the AHB-to-APB bridge.
//   - AHB transfer-type and response codes
//   - error-response FSM state type
//   - default address-map constants and one-hot slave-select codes
//   - helper that checks an AHB address against its transfer size
package ahb_apb_pkg;

  // AHB HTRANS encodings
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // AHB HRESP encodings
  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  // Default APB address map
  localparam logic [31:0] BASE_ADDR_DEF  = 32'h8000_0000;
  localparam logic [31:0] SLAVE_SPAN_DEF = 32'h0400_0000;
  localparam int unsigned NUM_SLAVES_DEF = 3;

  // One-hot slave selects for the default three-slave map
  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_S0   = 3'b001;
  localparam logic [2:0] SEL_S1   = 3'b010;
  localparam logic [2:0] SEL_S2   = 3'b100;

  // Two-cycle AHB ERROR response sequencer
  typedef enum logic [1:0] {
    ST_OK   = 2'b00,
    ST_ERR1 = 2'b01,
    ST_ERR2 = 2'b10
  } err_state_e;

  // True when the transfer size is at most a word and the address is aligned to it.
  function automatic logic ahb_size_aligned(input logic [2:0] size, input logic [1:0] addr_lsb);
    logic ok;
    case (size)
      3'b000:  ok = 1'b1;
      3'b001:  ok = ~addr_lsb[0];
      3'b010:  ok = (addr_lsb == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ahb_addr_decode.sv
// ahb_addr_decode: maps an AHB address onto the APB slave window.
//   haddr_i     in  32         AHB address
//   mapped_o    out 1          address lies in [BASE_ADDR, BASE_ADDR + NUM_SLAVES*SLAVE_SPAN)
//   tempselx_o  out NUM_SLAVES one-hot slave select, all zero when unmapped
module ahb_addr_decode
  import ahb_apb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = BASE_ADDR_DEF,
  parameter logic [31:0] SLAVE_SPAN = SLAVE_SPAN_DEF,
  parameter int unsigned NUM_SLAVES = NUM_SLAVES_DEF
) (
  input  logic [31:0]           haddr_i,
  output logic                  mapped_o,
  output logic [NUM_SLAVES-1:0] tempselx_o
);

  localparam int unsigned SpanLog2 = $clog2(SLAVE_SPAN);
  // Computed in 33 bits so a window ending at the top of the address space does not wrap.
  localparam logic [32:0] EndAddr = {1'b0, BASE_ADDR} + (33'(NUM_SLAVES) << SpanLog2);

  logic [31:0] offset;
  logic [31:0] slave_idx;

  always_comb begin
    mapped_o   = ({1'b0, haddr_i} >= {1'b0, BASE_ADDR}) && ({1'b0, haddr_i} < EndAddr);
    offset     = haddr_i - BASE_ADDR;
    slave_idx  = offset >> SpanLog2;
    tempselx_o = '0;
    for (int unsigned n = 0; n < NUM_SLAVES; n++) begin
      if (mapped_o && (slave_idx == n)) begin
        tempselx_o[n] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_slave_if.sv
// ahb_slave_if: AHB-side front end of the AHB-to-APB bridge.
//   Qualifies AHB transfers (valid), decodes the APB slave select (tempselx), pipelines
//   address/write-data/direction two deep, and owns the AHB response (forwards the APB
//   controller's ready or drives a two-cycle ERROR).
// Ports:
//   hclk, hresetn             clock, async active-low reset
//   hwrite, hreadyin, htrans, hsize, haddr, hwdata   AHB master side inputs
//   prdata, hr_readyout       from APB controller
//   valid, tempselx           qualified transfer and one-hot slave select (combinational)
//   haddr1/2, hwdata1/2, hwrite_reg/hwrite_reg1      1- and 2-deep pipelined copies
//   hrdata, hreadyout, hresp  AHB response to master
// Build option: define AHB_ALIGN_CHECK_EN to send oversize or misaligned transfers down the
// ERROR path; otherwise hsize is ignored and only unmapped addresses error.
module ahb_slave_if
  import ahb_apb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = BASE_ADDR_DEF,
  parameter logic [31:0] SLAVE_SPAN = SLAVE_SPAN_DEF,
  parameter int unsigned NUM_SLAVES = NUM_SLAVES_DEF
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hwrite,
  input  logic                  hreadyin,
  input  logic [1:0]            htrans,
  input  logic [2:0]            hsize,
  input  logic [31:0]           haddr,
  input  logic [31:0]           hwdata,
  input  logic [31:0]           prdata,
  input  logic                  hr_readyout,
  output logic                  valid,
  output logic [31:0]           haddr1,
  output logic [31:0]           haddr2,
  output logic [31:0]           hwdata1,
  output logic [31:0]           hwdata2,
  output logic                  hwrite_reg,
  output logic                  hwrite_reg1,
  output logic [NUM_SLAVES-1:0] tempselx,
  output logic [31:0]           hrdata,
  output logic                  hreadyout,
  output logic [1:0]            hresp
);

  logic mapped;
  logic active;
  logic ok_chk;
  logic bad;

  ahb_addr_decode #(
    .BASE_ADDR (BASE_ADDR),
    .SLAVE_SPAN(SLAVE_SPAN),
    .NUM_SLAVES(NUM_SLAVES)
  ) u_addr_decode (
    .haddr_i   (haddr),
    .mapped_o  (mapped),
    .tempselx_o(tempselx)
  );

`ifdef AHB_ALIGN_CHECK_EN
  assign ok_chk = ahb_size_aligned(hsize, haddr[1:0]);
`else
  logic unused_hsize;
  assign unused_hsize = ^hsize;
  assign ok_chk       = 1'b1;
`endif

  // Only NONSEQ/SEQ (htrans[1] set) on a ready bus is a real transfer.
  assign active = hreadyin & htrans[1];
  assign bad    = active & (~mapped | ~ok_chk);

  // ---------------------------------------------------------------------------
  // Error response FSM
  // ---------------------------------------------------------------------------
  err_state_e state_q, state_d;
  logic       err_stall_q, err_stall_d;  // ERR1: hold the bus
  logic       err_resp_q, err_resp_d;    // ERR1/ERR2: signal ERROR

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_OK:   if (bad) state_d = ST_ERR1;
      ST_ERR1: state_d = ST_ERR2;
      // A transfer presented in the last ERROR cycle is treated as a fresh one.
      ST_ERR2: state_d = bad ? ST_ERR1 : ST_OK;
      default: state_d = ST_OK;
    endcase
    err_stall_d = (state_d == ST_ERR1);
    err_resp_d  = (state_d != ST_OK);
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q     <= ST_OK;
      err_stall_q <= 1'b0;
      err_resp_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      err_stall_q <= err_stall_d;
      err_resp_q  <= err_resp_d;
    end
  end

  assign valid     = active & mapped & ok_chk & (state_q != ST_ERR1);
  assign hreadyout = err_resp_q ? ~err_stall_q : hr_readyout;
  assign hresp     = err_resp_q ? HRESP_ERROR : HRESP_OKAY;
  assign hrdata    = prdata;

  // ---------------------------------------------------------------------------
  // Address / data / direction pipeline; advances on every ready bus cycle.
  // ---------------------------------------------------------------------------
  logic [31:0] haddr1_q, haddr1_d, haddr2_q, haddr2_d;
  logic [31:0] hwdata1_q, hwdata1_d, hwdata2_q, hwdata2_d;
  logic        hwrite1_q, hwrite1_d, hwrite2_q, hwrite2_d;

  always_comb begin
    haddr1_d  = haddr1_q;
    haddr2_d  = haddr2_q;
    hwdata1_d = hwdata1_q;
    hwdata2_d = hwdata2_q;
    hwrite1_d = hwrite1_q;
    hwrite2_d = hwrite2_q;
    if (hreadyin) begin
      haddr1_d  = haddr;
      haddr2_d  = haddr1_q;
      // hwdata is valid in the data phase, so this lands one cycle behind its address.
      hwdata1_d = hwdata;
      hwdata2_d = hwdata1_q;
      hwrite1_d = hwrite;
      hwrite2_d = hwrite1_q;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      haddr1_q  <= '0;
      haddr2_q  <= '0;
      hwdata1_q <= '0;
      hwdata2_q <= '0;
      hwrite1_q <= 1'b0;
      hwrite2_q <= 1'b0;
    end else begin
      haddr1_q  <= haddr1_d;
      haddr2_q  <= haddr2_d;
      hwdata1_q <= hwdata1_d;
      hwdata2_q <= hwdata2_d;
      hwrite1_q <= hwrite1_d;
      hwrite2_q <= hwrite2_d;
    end
  end

  assign haddr1      = haddr1_q;
  assign haddr2      = haddr2_q;
  assign hwdata1     = hwdata1_q;
  assign hwdata2     = hwdata2_q;
  assign hwrite_reg  = hwrite1_q;
  assign hwrite_reg1 = hwrite2_q;

endmodule

// File: tb/tb_ahb_slave_if.sv
// Self-checking bench for ahb_slave_if: a table of single-cycle decode vectors plus
// hand-written sequences for reset, pipelining, stalls and the ERROR response.
module tb_ahb_slave_if;

  logic        hclk;
  logic        hresetn;
  logic        hwrite;
  logic        hreadyin;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [31:0] prdata;
  logic        hr_readyout;
  logic        valid;
  logic [31:0] haddr1, haddr2, hwdata1, hwdata2;
  logic        hwrite_reg, hwrite_reg1;
  logic [2:0]  tempselx;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic [1:0]  hresp;

  int n_total = 0;
  int n_pass  = 0;

  ahb_slave_if dut (
    .hclk       (hclk),
    .hresetn    (hresetn),
    .hwrite     (hwrite),
    .hreadyin   (hreadyin),
    .htrans     (htrans),
    .hsize      (hsize),
    .haddr      (haddr),
    .hwdata     (hwdata),
    .prdata     (prdata),
    .hr_readyout(hr_readyout),
    .valid      (valid),
    .haddr1     (haddr1),
    .haddr2     (haddr2),
    .hwdata1    (hwdata1),
    .hwdata2    (hwdata2),
    .hwrite_reg (hwrite_reg),
    .hwrite_reg1(hwrite_reg1),
    .tempselx   (tempselx),
    .hrdata     (hrdata),
    .hreadyout  (hreadyout),
    .hresp      (hresp)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  typedef struct {
    logic        rdy;
    logic [1:0]  trans;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        ctrl_rdy;
    logic        exp_valid;
    logic [2:0]  exp_sel;
    logic        exp_hready;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic drive(input logic [1:0] t, input logic [31:0] a, input logic w);
    htrans = t;
    haddr  = a;
    hwrite = w;
  endtask

  initial begin
    // Decode vectors, all evaluated from the OKAY state and none starting an error.
    //          rdy   trans  size    addr           prdata        crdy  valid sel     hready
    vecs[0]  = '{1'b1, 2'b10, 3'b010, 32'h8000_0000, 32'h1234_5678, 1'b1, 1'b1, 3'b001, 1'b1};
    vecs[1]  = '{1'b1, 2'b11, 3'b010, 32'h8400_0004, 32'hCAFE_0001, 1'b0, 1'b1, 3'b010, 1'b0};
    vecs[2]  = '{1'b1, 2'b10, 3'b010, 32'h8BFF_FFFC, 32'h0000_00FF, 1'b1, 1'b1, 3'b100, 1'b1};
    vecs[3]  = '{1'b1, 2'b00, 3'b010, 32'h8000_0000, 32'hA0A0_A0A0, 1'b1, 1'b0, 3'b001, 1'b1};
    vecs[4]  = '{1'b1, 2'b01, 3'b010, 32'h8400_0000, 32'h0F0F_0F0F, 1'b0, 1'b0, 3'b010, 1'b0};
    vecs[5]  = '{1'b0, 2'b10, 3'b010, 32'h8800_0000, 32'h1111_2222, 1'b1, 1'b0, 3'b100, 1'b1};
    vecs[6]  = '{1'b1, 2'b00, 3'b010, 32'h9000_0000, 32'h3333_4444, 1'b1, 1'b0, 3'b000, 1'b1};
    vecs[7]  = '{1'b1, 2'b01, 3'b010, 32'h7FFF_FFFC, 32'h5555_6666, 1'b1, 1'b0, 3'b000, 1'b1};
    vecs[8]  = '{1'b0, 2'b10, 3'b010, 32'h8C00_0000, 32'h7777_8888, 1'b0, 1'b0, 3'b000, 1'b0};
    vecs[9]  = '{1'b1, 2'b10, 3'b000, 32'h8000_0003, 32'h9999_AAAA, 1'b1, 1'b1, 3'b001, 1'b1};
    vecs[10] = '{1'b1, 2'b10, 3'b001, 32'h8400_0002, 32'hBBBB_CCCC, 1'b1, 1'b1, 3'b010, 1'b1};

    hresetn     = 1'b0;
    hwrite      = 1'b0;
    hreadyin    = 1'b1;
    htrans      = 2'b00;
    hsize       = 3'b010;
    haddr       = '0;
    hwdata      = '0;
    prdata      = '0;
    hr_readyout = 1'b1;
    step();
    step();
    hresetn = 1'b1;

    // Reset asserted mid-traffic while the error response is in progress.
    drive(2'b10, 32'h8000_0040, 1'b1);
    hwdata = 32'h1111_1111;
    step();
    drive(2'b10, 32'h9000_0000, 1'b1);
    hwdata = 32'h2222_2222;
    step();
    chk("pre_rst_hresp", 32'(hresp), 32'h1);
    chk("pre_rst_haddr1", haddr1, 32'h9000_0000);
    #2;
    hresetn = 1'b0;
    #1;
    chk("rst_haddr1", haddr1, 32'h0);
    chk("rst_haddr2", haddr2, 32'h0);
    chk("rst_hwdata1", hwdata1, 32'h0);
    chk("rst_hwdata2", hwdata2, 32'h0);
    chk("rst_hwrite_reg", 32'(hwrite_reg), 32'h0);
    chk("rst_hwrite_reg1", 32'(hwrite_reg1), 32'h0);
    chk("rst_hresp", 32'(hresp), 32'h0);
    hr_readyout = 1'b0;
    #1;
    chk("rst_hready_lo", 32'(hreadyout), 32'h0);
    hr_readyout = 1'b1;
    #1;
    chk("rst_hready_hi", 32'(hreadyout), 32'h1);
    drive(2'b00, 32'h0, 1'b0);
    hwdata = '0;
    step();
    step();
    hresetn = 1'b1;
    step();

    // Table-driven decode checks.
    for (int i = 0; i < 11; i++) begin
      hreadyin    = vecs[i].rdy;
      htrans      = vecs[i].trans;
      hsize       = vecs[i].size;
      haddr       = vecs[i].addr;
      prdata      = vecs[i].rdata;
      hr_readyout = vecs[i].ctrl_rdy;
      #2;
      chk($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_sel", i), 32'(tempselx), 32'(vecs[i].exp_sel));
      chk($sformatf("vec%0d_hready", i), 32'(hreadyout), 32'(vecs[i].exp_hready));
      chk($sformatf("vec%0d_hresp", i), 32'(hresp), 32'h0);
      chk($sformatf("vec%0d_hrdata", i), hrdata, vecs[i].rdata);
      step();
    end
    hreadyin    = 1'b1;
    hsize       = 3'b010;
    hr_readyout = 1'b1;

    // NONSEQ write, then its data phase.
    drive(2'b10, 32'h8000_0010, 1'b1);
    #2;
    chk("wr_valid", 32'(valid), 32'h1);
    chk("wr_sel", 32'(tempselx), 32'h1);
    step();
    chk("wr_haddr1", haddr1, 32'h8000_0010);
    chk("wr_hwrite_reg", 32'(hwrite_reg), 32'h1);
    drive(2'b00, 32'h8000_0100, 1'b0);
    hwdata = 32'hDEAD_BEEF;
    step();
    chk("wr_hwdata1", hwdata1, 32'hDEAD_BEEF);
    chk("wr_haddr2", haddr2, 32'h8000_0010);
    chk("wr_hwrite_reg1", 32'(hwrite_reg1), 32'h1);

    // Back-to-back NONSEQ to slaves 1 and 2.
    drive(2'b10, 32'h8400_0000, 1'b0);
    #2;
    chk("b2b_sel1", 32'(tempselx), 32'h2);
    step();
    drive(2'b10, 32'h8800_0004, 1'b0);
    #2;
    chk("b2b_sel2", 32'(tempselx), 32'h4);
    step();
    chk("b2b_haddr1", haddr1, 32'h8800_0004);
    chk("b2b_haddr2", haddr2, 32'h8400_0000);

    // Stall: pipeline holds while hreadyin is low.
    drive(2'b10, 32'h8000_0020, 1'b1);
    hwdata = 32'hA5A5_A5A5;
    step();
    hreadyin = 1'b0;
    drive(2'b10, 32'h8400_0008, 1'b0);
    hwdata = 32'h5555_5555;
    step();
    step();
    step();
    chk("stall_haddr1", haddr1, 32'h8000_0020);
    chk("stall_haddr2", haddr2, 32'h8800_0004);
    chk("stall_hwdata1", hwdata1, 32'hA5A5_A5A5);
    hreadyin = 1'b1;
    drive(2'b00, 32'h8000_0000, 1'b0);
    step();

    // Unmapped NONSEQ read: two-cycle ERROR, controller ready ignored.
    drive(2'b10, 32'h9000_0000, 1'b0);
    #2;
    chk("err_valid", 32'(valid), 32'h0);
    chk("err_sel", 32'(tempselx), 32'h0);
    chk("err_okay_before", 32'(hresp), 32'h0);
    step();
    drive(2'b00, 32'h8000_0000, 1'b0);
    hr_readyout = 1'b1;
    #1;
    chk("err1_hready", 32'(hreadyout), 32'h0);
    chk("err1_hresp", 32'(hresp), 32'h1);
    step();
    hr_readyout = 1'b0;
    #1;
    chk("err2_hready", 32'(hreadyout), 32'h1);
    chk("err2_hresp", 32'(hresp), 32'h1);
    step();
    chk("err_done_hresp", 32'(hresp), 32'h0);
    chk("err_done_hready", 32'(hreadyout), 32'h0);
    hr_readyout = 1'b1;

    // Good transfer blocked in ERR1, accepted in ERR2; bad in ERR2 re-enters ERR1.
    drive(2'b10, 32'h8C00_0000, 1'b0);
    step();
    drive(2'b10, 32'h8000_0000, 1'b0);
    #1;
    chk("err1_blocks_valid", 32'(valid), 32'h0);
    step();
    #1;
    chk("err2_accepts_valid", 32'(valid), 32'h1);
    drive(2'b10, 32'h8FFF_FFFC, 1'b0);
    step();
    drive(2'b00, 32'h8000_0000, 1'b0);
    #1;
    chk("err2_bad_rearm_hready", 32'(hreadyout), 32'h0);
    chk("err2_bad_rearm_hresp", 32'(hresp), 32'h1);
    step();
    step();
    chk("rearm_done_hresp", 32'(hresp), 32'h0);

    // Misaligned word access.
    hsize = 3'b010;
    drive(2'b10, 32'h8000_0002, 1'b0);
    #2;
`ifdef AHB_ALIGN_CHECK_EN
    chk("align_valid", 32'(valid), 32'h0);
    step();
    drive(2'b00, 32'h8000_0000, 1'b0);
    #1;
    chk("align_err1_hready", 32'(hreadyout), 32'h0);
    chk("align_err1_hresp", 32'(hresp), 32'h1);
    step();
    chk("align_err2_hready", 32'(hreadyout), 32'h1);
    chk("align_err2_hresp", 32'(hresp), 32'h1);
    step();
    chk("align_done_hresp", 32'(hresp), 32'h0);
`else
    chk("align_valid", 32'(valid), 32'h1);
    chk("align_sel", 32'(tempselx), 32'h1);
    chk("align_hresp", 32'(hresp), 32'h0);
    step();
    drive(2'b00, 32'h8000_0000, 1'b0);
    #1;
    chk("align_after_hresp", 32'(hresp), 32'h0);
    chk("align_after_hready", 32'(hreadyout), 32'h1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
